// File: rtl/fc_weight_sched.sv
// Weight/bias read scheduler for one fully-connected layer pass.
// Optional stall counter output is enabled by defining FC_SCHED_STALL_CNT_EN.
module fc_weight_sched #(
  parameter int unsigned WEIGHT_WORDS = 1200,
  parameter int unsigned BIAS_WORDS   = 32,
  parameter int unsigned ADDR_W       = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              weights_en,
  output logic [ADDR_W-1:0] weights_addr,
  output logic              bias_en,
  output logic [ADDR_W-1:0] bias_addr,
  output logic              w_valid,
  output logic              b_valid,
  output logic              busy,
  output logic              done
`ifdef FC_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StWeights, StBias, StDone} state_e;

  localparam logic [ADDR_W-1:0] WLast = ADDR_W'(WEIGHT_WORDS - 1);
  localparam logic [ADDR_W-1:0] BLast = ADDR_W'(BIAS_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] w_addr_d, b_addr_d;

  always_comb begin
    state_d  = state_q;
    w_addr_d = weights_addr;
    b_addr_d = bias_addr;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StWeights;
          w_addr_d = '0;
        end
      end
      StWeights: begin
        if (abort) begin
          state_d  = StIdle;
          w_addr_d = '0;
          b_addr_d = '0;
        end else if (out_ready) begin
          if (weights_addr == WLast) begin
            state_d  = StBias;
            b_addr_d = '0;
          end else begin
            w_addr_d = weights_addr + 1'b1;
          end
        end
      end
      StBias: begin
        if (abort) begin
          state_d  = StIdle;
          w_addr_d = '0;
          b_addr_d = '0;
        end else if (out_ready) begin
          if (bias_addr == BLast) begin
            state_d = StDone;
          end else begin
            b_addr_d = bias_addr + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (abort) begin
          w_addr_d = '0;
          b_addr_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      weights_addr <= '0;
      bias_addr    <= '0;
      weights_en   <= 1'b0;
      bias_en      <= 1'b0;
      w_valid      <= 1'b0;
      b_valid      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      weights_addr <= w_addr_d;
      bias_addr    <= b_addr_d;
      weights_en   <= (state_d == StWeights);
      bias_en      <= (state_d == StBias);
      w_valid      <= weights_en & out_ready;
      b_valid      <= bias_en & out_ready;
      busy         <= (state_d != StIdle);
      done         <= (state_d == StDone);
    end
  end

`ifdef FC_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state_q == StIdle && start && !abort) begin
      stall_cnt <= '0;
    end else if ((state_q == StWeights || state_q == StBias) && !out_ready &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_weight_sched.sv
// Self-checking bench for fc_weight_sched: directed scenarios plus random traffic,
// compared every cycle against a pass-level reference model.
module tb_fc_weight_sched;
  localparam int WW = 1200;
  localparam int BW = 32;
  localparam int AW = 11;
  localparam int PH_IDLE = 0, PH_W = 1, PH_B = 2, PH_DONE = 3;

  logic clk = 1'b0;
  logic rst, start, abort, out_ready;
  logic weights_en, bias_en, w_valid, b_valid, busy, done;
  logic [AW-1:0] weights_addr, bias_addr;
`ifdef FC_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fc_weight_sched #(.WEIGHT_WORDS(WW), .BIAS_WORDS(BW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .out_ready    (out_ready),
    .weights_en   (weights_en),
    .weights_addr (weights_addr),
    .bias_en      (bias_en),
    .bias_addr    (bias_addr),
    .w_valid      (w_valid),
    .b_valid      (b_valid),
    .busy         (busy),
    .done         (done)
`ifdef FC_SCHED_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;

  // Reference model: which phase of the pass we are in and the word index within it.
  int m_phase = PH_IDLE;
  int m_widx = 0, m_bidx = 0;
  int m_wv = 0, m_bv = 0;
  int m_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int was_w, was_b;
    was_w = (m_phase == PH_W);
    was_b = (m_phase == PH_B);
    if (rst) begin
      m_phase = PH_IDLE; m_widx = 0; m_bidx = 0; m_wv = 0; m_bv = 0; m_stall = 0;
      return;
    end
    m_wv = was_w && out_ready;
    m_bv = was_b && out_ready;
    if ((was_w || was_b) && !out_ready && m_stall < 65535) m_stall++;
    if (m_phase == PH_IDLE) begin
      if (start && !abort) begin
        m_phase = PH_W; m_widx = 0; m_stall = 0;
      end
    end else if (abort) begin
      m_phase = PH_IDLE; m_widx = 0; m_bidx = 0;
    end else if (m_phase == PH_W) begin
      if (out_ready) begin
        if (m_widx == WW - 1) begin m_phase = PH_B; m_bidx = 0; end
        else m_widx++;
      end
    end else if (m_phase == PH_B) begin
      if (out_ready) begin
        if (m_bidx == BW - 1) m_phase = PH_DONE;
        else m_bidx++;
      end
    end else begin
      m_phase = PH_IDLE;
    end
  endtask

  task automatic check_all();
    check("weights_en", 32'(weights_en), 32'(m_phase == PH_W));
    check("bias_en", 32'(bias_en), 32'(m_phase == PH_B));
    check("weights_addr", 32'(weights_addr), 32'(m_widx));
    check("bias_addr", 32'(bias_addr), 32'(m_bidx));
    check("w_valid", 32'(w_valid), 32'(m_wv));
    check("b_valid", 32'(b_valid), 32'(m_bv));
    check("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    check("done", 32'(done), 32'(m_phase == PH_DONE));
    check("en_exclusive", 32'(weights_en & bias_en), 32'd0);
`ifdef FC_SCHED_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  task automatic cyc(input logic s, input logic a, input logic r, input logic rs);
    start = s; abort = a; out_ready = r; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (done) n_done++;
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;

    // Reset held for three cycles.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_busy", 32'(busy), 32'd0);

    // Full pass with out_ready held high: done lands 1233 cycles after start.
    n_done = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    k = 1;
    while (!done && k < 1400) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      k++;
    end
    check("pass_length", 32'(k), 32'd1233);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("single_done", 32'(n_done), 32'd1);
    check("idle_after_pass", 32'(busy), 32'd0);

    // Five-cycle stall at weight address 600.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    while (m_phase == PH_W && m_widx < 600) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("stall_at", 32'(weights_addr), 32'd600);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_hold", 32'(weights_addr), 32'd600);
    check("stall_no_valid", 32'(w_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("stall_resume", 32'(weights_addr), 32'd601);
`ifdef FC_SCHED_STALL_CNT_EN
    check("stall_cnt5", 32'(stall_cnt), 32'd5);
`endif

    // Abort at bias address 10, then a fresh start.
    n_done = 0;
    while (!(m_phase == PH_B && m_bidx == 10) && m_phase != PH_IDLE)
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_at", 32'(bias_addr), 32'd10);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("abort_bias_en", 32'(bias_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_no_done", 32'(n_done), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("abort_beats_start", 32'(busy), 32'd0);

    // Restart; a second start at address 100 is ignored.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("restart_addr", 32'(weights_addr), 32'd0);
    check("restart_en", 32'(weights_en), 32'd1);
    while (m_phase == PH_W && m_widx < 100) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("busy_start_ignored", 32'(weights_addr), 32'd101);
    k = 0;
    while (m_phase != PH_IDLE && k < 1400) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      k++;
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("one_done", 32'(n_done), 32'd1);

    // Reset mid-pass at weight address 700.
    n_done = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    while (m_phase == PH_W && m_widx < 700) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_mid_en", 32'(weights_en), 32'd0);
    check("rst_mid_addr", 32'(weights_addr), 32'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_mid_no_done", 32'(n_done), 32'd0);

    // Random traffic.
    for (int i = 0; i < 8000; i++) begin
      cyc(1'(($urandom % 40) == 0), 1'(($urandom % 500) == 0),
          1'(($urandom % 4) != 0), 1'(($urandom % 4000) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
